alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//   Multi-cycle, handshaked successor to the combinational RV64I R-type ALU.
//   Width-parametrised. Adds an optional iterative MUL (RV M-ext, low half).
//   Inputs and outputs use valid/ready handshakes, so the block can be stalled
//   by the execute stage of the sequential core.
// PARAMETERS
//   XLEN    64  operand/result width; must be a power of 2, >= 8
//   MUL_EN  1   1: funct7=0000001/funct3=000 is MUL; 0: that encoding is illegal
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     request valid
//   in_ready   out  1     block can accept a request
//   funct3     in   3     RV funct3
//   funct7     in   7     RV funct7
//   rs1        in   XLEN  operand A
//   rs2        in   XLEN  operand B
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer accepts result
//   rd         out  XLEN  result
//   illegal    out  1     result is from an unsupported encoding (qualified by out_valid)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, out_valid=0, rd=0, illegal=0, mul counter=0.
//     Any operation in flight is aborted. Requests presented while rst_n=0 are ignored.
//   FSM states: IDLE, MUL, DONE.
//     IDLE: in_ready=1. Accept when in_valid&&in_ready.
//       Single-cycle op or illegal op: go to DONE.
//       MUL: go to MUL with cnt=0.
//     MUL: in_ready=0. Perform one shift-add step per cycle:
//       if mplr[0], acc+=mcand; then mcand<<=1, mplr>>=1, cnt++.
//       After exactly XLEN steps, rd=acc and go to DONE. No early termination.
//     DONE: out_valid=1. rd and illegal are held stable until out_valid&&out_ready.
//       in_ready=out_ready: a result handover and a new accept may happen in the same cycle.
//       Back-to-back single-cycle ops therefore sustain 1 op/cycle.
//       On handover with no new accept: go to IDLE, out_valid=0.
//   Latency, accept edge to out_valid: single-cycle/illegal = 1 cycle; MUL = XLEN+1 cycles.
//   Operands are captured at accept. Later changes on rs1/rs2/funct* do not affect the result.
//   Encodings (funct7/funct3):
//     0000000/000 ADD, /001 SLL, /010 SLT, /011 SLTU, /100 XOR, /101 SRL, /110 OR, /111 AND
//     0100000/000 SUB, 0100000/101 SRA, 0000001/000 MUL (MUL_EN=1 only)
//     Any other encoding: rd=0, illegal=1.
//   Arithmetic rules:
//     ADD, SUB, MUL wrap modulo 2^XLEN; MUL returns the low XLEN bits of the product.
//     Shift amount = rs2[$clog2(XLEN)-1:0]; the remaining rs2 bits are ignored.
//     SRA replicates rs1[XLEN-1].
//     SLT is a signed compare and SLTU unsigned; result is {XLEN-1 zeros, cmp}.
//   illegal is 0 for every legal result.
// TESTING (XLEN=64, MUL_EN=1 unless stated)
//   ADD rs1=FFFFFFFFFFFFFFFF rs2=1 -> rd=0, illegal=0, out_valid 1 cycle after accept.
//   SRA rs1=8000000000000000 rs2=0000000000000044 (shamt=4) -> rd=F800000000000000;
//     SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
//   MUL FFFFFFFFFFFFFFFF*3 -> rd=FFFFFFFFFFFFFFFD, out_valid exactly 65 cycles after accept;
//     in_ready=0 throughout.
//   Backpressure: hold out_ready=0 for 5 cycles -> rd, illegal and out_valid stable;
//     then stream 4 ADDs with out_ready=1 -> 1 result per cycle, in order.
//   Reset mid-MUL (rst_n low at step 20) -> out_valid=0 and rd=0 immediately;
//     after release, next ADD 2+3 -> 5.
//   Illegal 0100000/001, and MUL with MUL_EN=0 -> rd=0, illegal=1, latency 1 cycle.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle, handshaked RV64I R-type ALU with an optional iterative MUL
// (low half of the product). Single-cycle ops produce a result one cycle
// after accept. MUL runs one shift-add step per cycle for XLEN cycles, then
// spends one more cycle loading the result.
module alu_mc #(
    parameter int XLEN   = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_is_mul;
    logic            w_illegal;
    logic [XLEN-1:0] w_result;
    logic [SHW-1:0]  w_shamt;
    logic            w_mul_last;

    logic [XLEN-1:0] r_rd;
    logic            r_illegal;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplr;
    logic [CW-1:0]   r_cnt;

    assign w_shamt    = rs2[SHW-1:0];
    assign w_accept   = in_valid && in_ready;
    // The load cycle follows the XLEN-th step, giving XLEN+1 cycles of MUL latency.
    assign w_mul_last = (r_cnt == CW'(XLEN));
    assign rd         = r_rd;
    assign illegal    = r_illegal;

    // Decode the presented request and compute the single-cycle result.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_result  = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case ({funct7, funct3})
            10'b0000000_000: w_result = rs1 + rs2;
            10'b0000000_001: w_result = rs1 << w_shamt;
            10'b0000000_010: w_result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            10'b0000000_011: w_result = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            10'b0000000_100: w_result = rs1 ^ rs2;
            10'b0000000_101: w_result = rs1 >> w_shamt;
            10'b0000000_110: w_result = rs1 | rs2;
            10'b0000000_111: w_result = rs1 & rs2;
            10'b0100000_000: w_result = rs1 - rs2;
            10'b0100000_101: w_result = $unsigned($signed(rs1) >>> w_shamt);
            10'b0000001_000: begin
                if (MUL_EN) w_is_mul  = 1'b1;
                else        w_illegal = 1'b1;
            end
            default:         w_illegal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs; DONE can hand over and accept in one cycle.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (w_mul_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
                    else          w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture operands/result at accept, iterate the shift-add multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_illegal <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_illegal <= w_illegal;
            if (w_is_mul) begin
                r_acc   <= '0;
                r_mcand <= rs1;
                r_mplr  <= rs2;
                r_cnt   <= '0;
            end else begin
                r_rd <= w_result;
            end
        end else if (r_state == S_MUL) begin
            if (w_mul_last) begin
                r_rd <= r_acc;
            end else begin
                if (r_mplr[0]) r_acc <= r_acc + r_mcand;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

endmodule
